// File: rtl/alu_issue_ctrl_if.sv
// Request, ALU and result signals between issue logic, the ALU and the result consumer.
// The master modport is the issue controller. The slave modport is its environment:
// the producer, the combinational ALU and the consumer.
interface alu_issue_ctrl_if;
  // Request handshake from decode/issue
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] src_a;
  logic [31:0] src_b;

  // Drive toward the combinational ALU, and its result
  logic [3:0]  ctl_lines;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] alu_result;

  // Result handshake toward the consumer
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_err;

  // Status
  logic        busy;

  modport master (
    input  in_valid, alu_op, funct, src_a, src_b, alu_result, res_ready,
    output in_ready, ctl_lines, op_a, op_b, res_valid, res_data, res_err, busy
  );

  modport slave (
    output in_valid, alu_op, funct, src_a, src_b, alu_result, res_ready,
    input  in_ready, ctl_lines, op_a, op_b, res_valid, res_data, res_err, busy
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller. It accepts one decoded operation at a time and maps it to an
// ALU control code. It holds control and operands on the ALU for an op-dependent
// number of cycles, then returns the registered result. Unsupported operations are
// flagged through res_err and return a zero result.
module alu_issue_ctrl #(
  parameter int unsigned MUL_LAT = 3  // cycles multiply is held on the ALU, 1..15
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_issue_ctrl_if.master bus
);

  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0011;
  localparam logic [3:0] CTL_MUL = 4'b0100;
  localparam logic [3:0] CTL_NOP = 4'b0000;
  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);

  if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_mul_lat
    $error("alu_issue_ctrl: MUL_LAT must be in 1..15");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [3:0]  ctl_q;
  logic [31:0] op_a_q;
  logic [31:0] op_b_q;
  logic        err_q;
  logic [31:0] res_data_q;
  logic        res_err_q;
  logic        res_valid_q;
  logic        in_ready_q;
  logic        busy_q;

  logic [3:0]  ctl_d;
  logic        err_d;
  logic [3:0]  cnt_load_d;

  // Decode the incoming request into an ALU control code, an error flag and a hold count.
  always_comb begin
    // NOTE: every output gets a default first so that no path leaves it unassigned,
    // which would otherwise infer a latch.
    ctl_d = CTL_NOP;
    err_d = 1'b1;
    unique case (bus.alu_op)
      2'b00: begin ctl_d = CTL_ADD; err_d = 1'b0; end
      2'b01: begin ctl_d = CTL_SUB; err_d = 1'b0; end
      2'b10: begin
        unique case (bus.funct)
          6'b100000: begin ctl_d = CTL_ADD; err_d = 1'b0; end
          6'b100010: begin ctl_d = CTL_SUB; err_d = 1'b0; end
          6'b011000: begin ctl_d = CTL_MUL; err_d = 1'b0; end
          default:   begin ctl_d = CTL_NOP; err_d = 1'b1; end
        endcase
      end
      default: begin ctl_d = CTL_NOP; err_d = 1'b1; end
    endcase
    cnt_load_d = (ctl_d == CTL_MUL) ? MUL_CNT : 4'd1;
  end

  // Issue FSM. Handshake and status outputs are registered with the state.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. All updates then
    // see the pre-edge values, regardless of statement order.
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      ctl_q       <= CTL_NOP;
      op_a_q      <= 32'd0;
      op_b_q      <= 32'd0;
      err_q       <= 1'b0;
      res_data_q  <= 32'd0;
      res_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            op_a_q     <= bus.src_a;
            op_b_q     <= bus.src_b;
            ctl_q      <= ctl_d;
            err_q      <= err_d;
            cnt_q      <= cnt_load_d;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_EXEC;
          end
        end
        S_EXEC: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            res_data_q  <= err_q ? 32'd0 : bus.alu_result;
            res_err_q   <= err_q;
            res_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          // ctl_lines returns to NOP in IDLE. Operands keep their last values.
          if (bus.res_ready) begin
            ctl_q       <= CTL_NOP;
            res_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          ctl_q       <= CTL_NOP;
          res_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.ctl_lines = ctl_q;
  assign bus.op_a      = op_a_q;
  assign bus.op_b      = op_b_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_err   = res_err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl. A behavioural ALU drives alu_result.
// Stimulus pushes hand-computed expected results into a queue. A monitor pops the
// queue and compares each result at its handshake.
module tb_alu_issue_ctrl;
  localparam int unsigned MUL_LAT = 3;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk;
  logic rst_n;
  alu_issue_ctrl_if bus ();

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  alu_issue_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU. The unknown code returns a marker value, so a leak into res_data shows.
  always_comb begin
    case (bus.ctl_lines)
      4'b0010: bus.alu_result = bus.op_a + bus.op_b;
      4'b0011: bus.alu_result = bus.op_a - bus.op_b;
      4'b0100: bus.alu_result = bus.op_a * bus.op_b;
      default: bus.alu_result = 32'hDEAD_BEEF;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a result is taken when valid and ready are both seen mid-cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result", {31'd0, bus.res_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("res_data", bus.res_data, e.data);
        check("res_err", {31'd0, bus.res_err}, {31'd0, e.err});
      end
    end
  end

  // Issue one op. Checks the control code at accept, the latency, and the held
  // control at result time. With post set (res_ready high), it also checks the
  // return to IDLE after the handshake.
  task automatic issue(input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_data, input logic exp_err,
                       input logic [3:0] exp_ctl, input int exp_lat, input bit post);
    int   lat;
    int   guard;
    exp_t e;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    check("in_ready_before_issue", {31'd0, bus.in_ready}, 32'd1);
    bus.alu_op   = op;
    bus.funct    = fn;
    bus.src_a    = a;
    bus.src_b    = b;
    bus.in_valid = 1'b1;
    e.data = exp_data;
    e.err  = exp_err;
    sb_q.push_back(e);
    tick();  // accept edge E0
    bus.in_valid = 1'b0;
    check("ctl_at_accept", {28'd0, bus.ctl_lines}, {28'd0, exp_ctl});
    check("in_ready_exec", {31'd0, bus.in_ready}, 32'd0);
    lat = 0;
    while (lat < 20) begin
      tick();
      lat++;
      if (bus.res_valid === 1'b1) break;
    end
    check("latency", lat, exp_lat);
    check("ctl_held_done", {28'd0, bus.ctl_lines}, {28'd0, exp_ctl});
    if (post) begin
      tick();  // handshake edge Ed
      check("in_ready_after_hs", {31'd0, bus.in_ready}, 32'd1);
      check("res_valid_after_hs", {31'd0, bus.res_valid}, 32'd0);
      check("ctl_idle", {28'd0, bus.ctl_lines}, 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    int   guard;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.alu_op    = 2'b00;
    bus.funct     = 6'd0;
    bus.src_a     = 32'd7;
    bus.src_b     = 32'd5;
    bus.res_ready = 1'b1;

    // Reset held for two edges while in_valid is asserted: nothing is accepted.
    for (int i = 0; i < 2; i++) begin
      tick();
      check("busy_in_reset", {31'd0, bus.busy}, 32'd0);
      check("ctl_in_reset", {28'd0, bus.ctl_lines}, 32'd0);
    end
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    check("in_ready_after_reset", {31'd0, bus.in_ready}, 32'd1);
    check("res_valid_after_reset", {31'd0, bus.res_valid}, 32'd0);
    check("busy_after_reset", {31'd0, bus.busy}, 32'd0);
    check("res_data_after_reset", bus.res_data, 32'd0);

    // Directed operations, with res_ready held high
    issue(2'b00, 6'b000000, 32'd7, 32'd5, 32'd12, 1'b0, 4'b0010, 1, 1'b1);
    issue(2'b10, 6'b100010, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 4'b0011, 1, 1'b1);
    issue(2'b10, 6'b011000, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000, 1'b0, 4'b0100, MUL_LAT, 1'b1);
    issue(2'b10, 6'b100101, 32'd3, 32'd4, 32'd0, 1'b1, 4'b0000, 1, 1'b1);
    issue(2'b11, 6'b100000, 32'd1, 32'd1, 32'd0, 1'b1, 4'b0000, 1, 1'b1);
    issue(2'b01, 6'b000000, 32'd10, 32'd3, 32'd7, 1'b0, 4'b0011, 1, 1'b1);
    issue(2'b10, 6'b100000, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 4'b0010, 1, 1'b1);

    // Backpressure: the result waits in DONE while a second request is held.
    bus.res_ready = 1'b0;
    issue(2'b00, 6'b000000, 32'd1, 32'd2, 32'd3, 1'b0, 4'b0010, 1, 1'b0);
    bus.alu_op   = 2'b01;
    bus.src_a    = 32'd9;
    bus.src_b    = 32'd4;
    bus.in_valid = 1'b1;
    e.data = 32'd5;
    e.err  = 1'b0;
    sb_q.push_back(e);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_res_valid", {31'd0, bus.res_valid}, 32'd1);
      check("bp_res_data", bus.res_data, 32'd3);
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("bp_ctl_held", {28'd0, bus.ctl_lines}, 32'd2);
    end
    bus.res_ready = 1'b1;
    tick();  // handshake edge: back to IDLE, second op not yet taken
    check("bp_idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("bp_idle_busy", {31'd0, bus.busy}, 32'd0);
    tick();  // second op accepted here
    bus.in_valid = 1'b0;
    check("bp_second_accept", {31'd0, bus.busy}, 32'd1);
    check("bp_second_ctl", {28'd0, bus.ctl_lines}, 32'd3);
    guard = 0;
    while (bus.res_valid !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    check("bp_second_valid", {31'd0, bus.res_valid}, 32'd1);
    tick();

    // Reset during a multiply aborts it without presenting a result.
    bus.alu_op   = 2'b10;
    bus.funct    = 6'b011000;
    bus.src_a    = 32'd6;
    bus.src_b    = 32'd7;
    bus.in_valid = 1'b1;
    tick();  // accept E0
    bus.in_valid = 1'b0;
    check("mul_accepted", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    tick();  // reset edge E0+1
    rst_n = 1'b1;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("abort_ctl", {28'd0, bus.ctl_lines}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_no_valid", {31'd0, bus.res_valid}, 32'd0);
    end
    issue(2'b00, 6'b000000, 32'd100, 32'd23, 32'd123, 1'b0, 4'b0010, 1, 1'b1);

    repeat (3) tick();
    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
